// File: rtl/seq_code_detector.sv
// seq_code_detector: programmable colour-sequence lock with press/release qualification,
// inactivity timeout, consecutive-failure counting and timed lockout.
module seq_code_detector #(
    parameter int NUM_COLORS  = 3,
    parameter int MAX_LEN     = 8,
    parameter int TIMEOUT_CYC = 255,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYC    = 1023,
    localparam int CW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1,
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [NUM_COLORS-1:0] Colors,
    input  logic                  CfgWe,
    input  logic [IW-1:0]         CfgIdx,
    input  logic [CW-1:0]         CfgSym,
    input  logic                  CfgLenWe,
    input  logic [LW-1:0]         CfgLen,
    output logic                  U,
    output logic                  Fail,
    output logic                  Busy,
    output logic                  Locked,
    output logic [LW-1:0]         Progress
);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int KW = (LOCK_CYC > 2) ? $clog2(LOCK_CYC) : 1;
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [IW:0] IDX_LIM = (IW+1)'(MAX_LEN);
    localparam logic [CW:0] SYM_LIM = (CW+1)'(NUM_COLORS);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYC - 1);
    localparam logic [FW-1:0] FAIL_LIM = FW'(MAX_FAILS);
    typedef enum logic [2:0] {IDLE, COLLECT, RELEASE, MATCH, FAILST, LOCK} state_t;
    state_t state, state_n;
    logic [CW-1:0] code [MAX_LEN];
    logic [LW-1:0] len, prog_n;
    logic [TW-1:0] timer, timer_n;
    logic [KW-1:0] lcnt, lcnt_n;
    logic [FW-1:0] fails, fails_n;
    logic [NUM_COLORS-1:0] held, held_n;
    logic [CW-1:0] sym;
    logic valid, tmo;
    assign valid = $onehot(Colors);
    assign tmo = timer == TMO;
    always_comb begin
        sym = '0;
        for (int i = 0; i < NUM_COLORS; i++)
            if (Colors[i]) sym = CW'(i);
    end
    always_comb begin
        state_n = state;
        prog_n = Progress;
        timer_n = timer;
        lcnt_n = lcnt;
        fails_n = fails;
        held_n = held;
        case (state)
            IDLE: begin
                prog_n = '0;
                timer_n = '0;
                state_n = Start ? COLLECT : IDLE;
            end
            COLLECT: begin
                if (Colors == '0) begin
                    state_n = tmo ? FAILST : COLLECT;
                    timer_n = timer + TW'(1);
                end else if (valid && sym == code[Progress[IW-1:0]]) begin
                    prog_n = Progress + LW'(1);
                    timer_n = '0;
                    held_n = Colors;
                    state_n = (Progress + LW'(1) == len) ? MATCH : RELEASE;
                end else
                    state_n = FAILST;
            end
            RELEASE: begin
                if (Colors == held) begin
                    state_n = tmo ? FAILST : RELEASE;
                    timer_n = timer + TW'(1);
                end else if (Colors == '0) begin
                    state_n = COLLECT;
                    timer_n = '0;
                end else
                    state_n = FAILST;
            end
            MATCH: begin
                prog_n = '0;
                fails_n = '0;
                state_n = IDLE;
            end
            FAILST: begin
                prog_n = '0;
                fails_n = (fails + FW'(1) == FAIL_LIM) ? '0 : fails + FW'(1);
                lcnt_n = KW'(LOCK_CYC - 1);
                state_n = (fails + FW'(1) == FAIL_LIM) ? LOCK : IDLE;
            end
            LOCK: begin
                prog_n = '0;
                lcnt_n = lcnt - KW'(1);
                state_n = (lcnt == '0) ? IDLE : LOCK;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            Progress <= '0;
            timer <= '0;
            lcnt <= '0;
            fails <= '0;
            held <= '0;
            len <= LW'(4);
            for (int i = 0; i < MAX_LEN; i++)
                code[i] <= (i == 1) ? CW'(2) : (i == 2) ? CW'(1) : '0;
            U <= 1'b0;
            Fail <= 1'b0;
            Busy <= 1'b0;
            Locked <= 1'b0;
        end else begin
            state <= state_n;
            Progress <= prog_n;
            timer <= timer_n;
            lcnt <= lcnt_n;
            fails <= fails_n;
            held <= held_n;
            U <= state_n == MATCH;
            Fail <= state_n == FAILST;
            Busy <= state_n == COLLECT || state_n == RELEASE;
            Locked <= state_n == LOCK;
            // Configuration only lands while idle, so a live entry never sees its code change.
            if (state == IDLE) begin
                if (CfgWe && {1'b0, CfgIdx} < IDX_LIM && {1'b0, CfgSym} < SYM_LIM)
                    code[CfgIdx] <= CfgSym;
                if (CfgLenWe && CfgLen != '0 && CfgLen <= LEN_MAX)
                    len <= CfgLen;
            end
        end
    end
endmodule

// File: tb/tb_seq_code_detector.sv
// tb_seq_code_detector: directed vector table plus hand-written timeout, lockout and config sequences.
module tb_seq_code_detector;
    localparam logic [2:0] R = 3'b001, G = 3'b010, B = 3'b100;
    logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0;
    logic [2:0] Colors = '0;
    logic CfgWe = 1'b0, CfgLenWe = 1'b0;
    logic [2:0] CfgIdx = '0;
    logic [1:0] CfgSym = '0;
    logic [3:0] CfgLen = '0;
    logic U, Fail, Busy, Locked;
    logic [3:0] Progress;
    int n_cmp = 0, n_bad = 0;

    seq_code_detector #(.TIMEOUT_CYC(8), .LOCK_CYC(16)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Colors(Colors),
        .CfgWe(CfgWe), .CfgIdx(CfgIdx), .CfgSym(CfgSym),
        .CfgLenWe(CfgLenWe), .CfgLen(CfgLen),
        .U(U), .Fail(Fail), .Busy(Busy), .Locked(Locked), .Progress(Progress)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       start;
        logic [2:0] col;
        logic [7:0] exp;
    } vec_t;
    vec_t v[$];

    function automatic void add(input logic s, input logic [2:0] c, input logic u, input logic f,
                                input logic b, input logic l, input int p);
        vec_t t;
        t.start = s;
        t.col = c;
        t.exp = {u, f, b, l, 4'(p)};
        v.push_back(t);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        Start = 1'b0;
        Colors = '0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    task automatic press(input logic [2:0] c);
        Colors = c;
        tick();
        Colors = '0;
        tick();
    endtask

    task automatic enter(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                         input logic [2:0] last, input int plen, input string name);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        press(c0);
        if (c1 != '0) press(c1);
        if (c2 != '0) press(c2);
        Colors = last;
        tick();
        Colors = '0;
        chk({name, "_u"}, {U, Fail, Progress}, {1'b1, 1'b0, 4'(plen)});
        tick();
        chk({name, "_idle"}, {U, Busy, Progress}, 0);
    endtask

    initial begin
        int n;
        // Single-cycle presses, default R,B,G,R
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, R, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 1);
        add(0, B, 0, 0, 1, 0, 2);
        add(0, 0, 0, 0, 1, 0, 2);
        add(0, G, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 1, 0, 3);
        add(0, R, 1, 0, 0, 0, 4);
        add(0, 0, 0, 0, 0, 0, 0);
        // Wrong second symbol
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, R, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 1);
        add(0, G, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);
        // Held presses with gaps
        add(1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) add(0, R, 0, 0, 1, 0, 1);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) add(0, B, 0, 0, 1, 0, 2);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 1, 0, 2);
        for (int k = 0; k < 3; k++) add(0, G, 0, 0, 1, 0, 3);
        for (int k = 0; k < 2; k++) add(0, 0, 0, 0, 1, 0, 3);
        add(0, R, 1, 0, 0, 0, 4);
        add(0, R, 0, 0, 0, 0, 0);
        add(0, R, 0, 0, 0, 0, 0);
        // Multi-hot press is invalid
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, 3'b011, 0, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0);
        // Different colour while still holding
        add(1, 0, 0, 0, 1, 0, 0);
        add(0, R, 0, 0, 1, 0, 1);
        add(0, B, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0);

        do_reset();
        chk("reset_outputs", {U, Fail, Busy, Locked, Progress}, 0);
        foreach (v[i]) begin
            Start = v[i].start;
            Colors = v[i].col;
            tick();
            chk($sformatf("vec%0d", i), {U, Fail, Busy, Locked, Progress}, v[i].exp);
        end
        Start = 1'b0;
        Colors = '0;

        // Inactivity timeout: Fail exactly 8 cycles after entering COLLECT
        do_reset();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("timeout_t%0d", k), Fail, k == 8);
        end
        tick();
        chk("timeout_idle", {Fail, Busy}, 0);

        // Three wrong entries -> 16-cycle lockout ignoring Start
        do_reset();
        for (int a = 0; a < 3; a++) begin
            Start = 1'b1;
            tick();
            Start = 1'b0;
            Colors = G;
            tick();
            Colors = '0;
            chk($sformatf("lock_fail%0d", a), {Fail, Locked}, 2'b10);
            if (a < 2) tick();
        end
        Start = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!Locked) break;
            n++;
            if (Busy) chk("lock_busy", Busy, 0);
        end
        Start = 1'b0;
        chk("lock_len", n, 16);
        chk("lock_released", {Locked, Busy}, 0);
        enter(R, B, G, R, 4, "post_lock");

        // Programmed 2-symbol code; write and Start together
        do_reset();
        CfgLenWe = 1'b1;
        CfgLen = 4'd2;
        CfgWe = 1'b1;
        CfgIdx = 3'd0;
        CfgSym = 2'd2;
        tick();
        CfgLenWe = 1'b0;
        CfgIdx = 3'd1;
        CfgSym = 2'd1;
        Start = 1'b1;
        tick();
        CfgWe = 1'b0;
        Start = 1'b0;
        chk("cfg_start_busy", Busy, 1);
        press(B);
        Colors = G;
        tick();
        Colors = '0;
        chk("cfg_match", {U, Progress}, {1'b1, 4'd2});
        tick();
        // Writes while busy are dropped
        Start = 1'b1;
        tick();
        Start = 1'b0;
        CfgWe = 1'b1;
        CfgIdx = 3'd0;
        CfgSym = 2'd0;
        CfgLenWe = 1'b1;
        CfgLen = 4'd1;
        tick();
        CfgWe = 1'b0;
        CfgLenWe = 1'b0;
        press(B);
        Colors = G;
        tick();
        Colors = '0;
        chk("busy_write_dropped", {U, Progress}, {1'b1, 4'd2});
        tick();
        // Out-of-range writes in IDLE are dropped
        CfgLenWe = 1'b1;
        CfgLen = 4'd0;
        CfgWe = 1'b1;
        CfgIdx = 3'd0;
        CfgSym = 2'd3;
        tick();
        CfgLen = 4'd9;
        tick();
        CfgLenWe = 1'b0;
        CfgWe = 1'b0;
        enter(B, 3'b000, 3'b000, G, 2, "bad_cfg_dropped");
        // Reset mid-entry aborts and restores the default code
        Start = 1'b1;
        tick();
        Start = 1'b0;
        Colors = B;
        tick();
        chk("mid_entry_prog", Progress, 1);
        Rst = 1'b1;
        tick();
        chk("rst_mid_outputs", {U, Fail, Busy, Locked, Progress}, 0);
        Rst = 1'b0;
        Colors = '0;
        tick();
        chk("rst_idle_outputs", {U, Fail, Busy, Locked, Progress}, 0);
        enter(R, B, G, R, 4, "default_restored");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
